alu_result_stage: RTL

- Pipeline stage directly downstream of the 32-bit ALU (ports sum, zout, N, V; 3-bit op gin).
- Registers each ALU result with its flags and evaluates the branch condition from those flags, giving the next-PC select.
- Holds a committed status-flag register.
- Two-entry valid/ready skid buffer, so back-pressure from the memory/writeback side never drops an ALU result.

---
 rtl/alu_result_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: registers ALU beats with branch resolution, commits status flags,
// and buffers two beats (main + skid). Optional sticky overflow via ALU_STICKY_OVF_EN.
module alu_result_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_result,
  input  logic         in_z,
  input  logic         in_n,
  input  logic         in_v,
  input  logic [2:0]   in_brop,
  input  logic         in_setflags,
  input  logic [W-1:0] in_pc4,
  input  logic [W-1:0] in_target,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_taken,
  output logic [W-1:0] out_next_pc,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_v,
  input  logic         ovf_clr,
  output logic         ovf_sticky
);

  typedef struct packed {
    logic [W-1:0] result;
    logic         taken;
    logic [W-1:0] next_pc;
    logic         z;
    logic         n;
    logic         v;
    logic         setflags;
  } entry_t;

  // Valid/ready: a beat moves on any edge where valid & ready are both high;
  // in_ready is purely registered (skid empty), so it never depends on out_ready.
  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   flag_z_q, flag_z_d, flag_n_q, flag_n_d, flag_v_q, flag_v_d;
  logic   ovf_sticky_q, ovf_sticky_d;
  logic   accept, xfer;

  function automatic logic branch_taken(input logic [2:0] brop, input logic z,
                                        input logic n, input logic v);
    logic t;
    case (brop)
      3'b001:  t = z;
      3'b010:  t = ~z;
      3'b011:  t = n ^ v;
      3'b100:  t = ~(n ^ v);
      3'b110:  t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_comb begin
    in_entry          = '0;
    in_entry.result   = in_result;
    in_entry.taken    = branch_taken(in_brop, in_z, in_n, in_v);
    in_entry.next_pc  = in_entry.taken ? in_target : in_pc4;
    in_entry.z        = in_z;
    in_entry.n        = in_n;
    in_entry.v        = in_v;
    in_entry.setflags = in_setflags;
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign xfer     = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    flag_z_d     = flag_z_q;
    flag_n_d     = flag_n_q;
    flag_v_d     = flag_v_q;
    ovf_sticky_d = 1'b0;

    if (!main_valid_q || xfer) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end

    // Flags commit on transfer even when a flush kills the buffers this cycle.
    if (xfer && main_q.setflags) begin
      flag_z_d = main_q.z;
      flag_n_d = main_q.n;
      flag_v_d = main_q.v;
    end

`ifdef ALU_STICKY_OVF_EN
    ovf_sticky_d = ovf_sticky_q;
    if (xfer && main_q.v) ovf_sticky_d = 1'b1;
    else if (ovf_clr)     ovf_sticky_d = 1'b0;
`endif

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

`ifndef ALU_STICKY_OVF_EN
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_n_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      flag_z_q     <= flag_z_d;
      flag_n_q     <= flag_n_d;
      flag_v_q     <= flag_v_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_result  = main_q.result;
  assign out_taken   = main_q.taken;
  assign out_next_pc = main_q.next_pc;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign flag_v      = flag_v_q;
  assign ovf_sticky  = ovf_sticky_q;

endmodule
